// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: coin codes and clock rate.
// The vending FSM decodes the same coin codes this front end produces.
package vending_pkg;

  localparam int CLK_HZ = 50_000_000;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [1:0] val;
  } coin_hold_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-flop synchroniser, stable-level debounce counter and a
// one-cycle pulse when the debounced level rises.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, rise_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      // any return to the accepted level restarts qualification
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        stable_q <= sync2_q;
        rise_q   <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin front end: debounces both coin inputs, rejects simultaneous presses and
// offers single coins to the vending FSM through a one-deep valid/ready slot.
module coin_input_conditioner
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       in1,
  input  logic       in0_5,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [1:0] coin_val,
  output logic       coin_err,
  output logic [7:0] err_cnt
);

  logic rise_one, rise_half;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_one (
    .clk_i (clk_50MHz),
    .rst_ni(reset),
    .din_i (in1),
    .rise_o(rise_one)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_half (
    .clk_i (clk_50MHz),
    .rst_ni(reset),
    .din_i (in0_5),
    .rise_o(rise_half)
  );

  coin_hold_t hold_q, hold_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q;
  logic       xfer, both, ev;
  logic [1:0] ev_code;

  assign xfer    = hold_q.valid & coin_ready;
  assign both    = rise_one & rise_half;
  assign ev      = rise_one ^ rise_half;
  assign ev_code = rise_one ? COIN_ONE : COIN_HALF;

  // a slot being drained this cycle can accept the new coin without loss
  always_comb begin
    hold_d = hold_q;
    err_d  = both | (ev & hold_q.valid & ~xfer);
    if (!hold_q.valid || xfer) begin
      hold_d.valid = ev;
      hold_d.val   = ev ? ev_code : COIN_NONE;
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      hold_q    <= '{valid: 1'b0, val: COIN_NONE};
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      hold_q <= hold_d;
      err_q  <= err_d;
      if (err_d) err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  assign coin_valid = hold_q.valid;
  assign coin_val   = hold_q.val;
  assign coin_err   = err_q;
  assign err_cnt    = err_cnt_q;

endmodule
